// File: rtl/mdu_unit_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies and
// the md-class instruction classifier used by the conflict controller.
package mdu_unit_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1a;
    localparam logic [5:0] FN_DIVU     = 6'h1b;

    // True for any instruction that reads or writes HI/LO.
    function automatic logic is_md_class(input logic [31:0] instr);
        logic res;
        res = 1'b0;
        if (instr[31:26] == OPC_SPECIAL) begin
            case (instr[5:0])
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: res = 1'b1;
                default:                            res = 1'b0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/mdu_unit_divider.sv
// Signed/unsigned divide core: magnitude divide with sign fix-up.
// Remainder follows the dividend's sign; MIN/-1 wraps back to MIN naturally.
module md_divider
    import mdu_unit_pkg::*;
(
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    output logic [XLEN-1:0] quot_c,
    output logic [XLEN-1:0] rem_c,
    output logic            div0_c
);

    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] uq;
    logic [XLEN-1:0] ur;

    always_comb begin
        neg_a  = is_signed & dividend[XLEN-1];
        neg_b  = is_signed & divisor[XLEN-1];
        mag_a  = neg_a ? (~dividend + XLEN'(1)) : dividend;
        mag_b  = neg_b ? (~divisor + XLEN'(1)) : divisor;
        div0_c = (divisor == '0);
        uq     = div0_c ? '0 : (mag_a / mag_b);
        ur     = div0_c ? '0 : (mag_a % mag_b);
        quot_c = (neg_a ^ neg_b) ? (~uq + XLEN'(1)) : uq;
        rem_c  = neg_a ? (~ur + XLEN'(1)) : ur;
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed from latched operands and committed on the last busy edge.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e          op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    md_op_e          op_in;
    logic            mul_signed;
    logic            is_mul;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quot_c;
    logic [XLEN-1:0] rem_c;
    logic            div0_c;

    assign op_in = md_op_e'(op);

    // Sign-extend to full product width so one multiplier serves both flavours.
    always_comb begin
        mul_signed = (op_q == MD_MULT);
        is_mul     = (op_q == MD_MULT) || (op_q == MD_MULTU);
        a_ext      = {{XLEN{mul_signed & a_q[XLEN-1]}}, a_q};
        b_ext      = {{XLEN{mul_signed & b_q[XLEN-1]}}, b_q};
        prod       = a_ext * b_ext;
    end

    md_divider u_div (
        .dividend  (a_q),
        .divisor   (b_q),
        .is_signed (op_q == MD_DIV),
        .quot_c    (quot_c),
        .rem_c     (rem_c),
        .div0_c    (div0_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op_in)
                        MD_MULT, MD_MULTU: begin
                            op_d    = op_in;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            op_d    = op_in;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last busy cycle: commit; a zero divisor leaves HI/LO untouched.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    if (is_mul) begin
                        hi_d = prod[2*XLEN-1:XLEN];
                        lo_d = prod[XLEN-1:0];
                    end else if (!div0_c) begin
                        hi_d = rem_c;
                        lo_d = quot_c;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
